// File: rtl/travel_plan_seq.sv
// travel_plan_seq
//   Travel-plan sequencer for the maze runner. Latches the 16-bit plan word
//   from the UART receiver, watches line presence for confirmed gaps, and at
//   each gap issues the next 2-bit maneuver (LSB pair first) to navigation.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cmd[15:0]       travel plan word, bits [1:0] consumed first
//   cmd_rdy         level, cmd is valid
//   clr_cmd_rdy     one-cycle acknowledge of cmd_rdy
//   line_present    IR line detected
//   turn_done       one-cycle pulse, turn-around complete
//   go              enable line following / motors
//   veer_rght       bias right until line reacquired
//   veer_lft        bias left until line reacquired
//   turn_ard        execute turn-around until turn_done
//   buzz_en         piezo enable while stopped at end of plan
//   plan_idx[2:0]   index of the next action to be consumed
//
// Configuration macro:
//   PLAN_LOOP_EN    defined: plan rotates so consumed actions recirculate and
//                   plan_idx wraps 7->0. Undefined: zero-fill shift and
//                   plan_idx saturates at 7.
module travel_plan_seq #(
    parameter int FAST_SIM  = 1,
    parameter int GAP_CYC   = (FAST_SIM != 0) ? 512 : 32768,
    parameter int REACQ_CYC = (FAST_SIM != 0) ? 512 : 32768
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    input  logic        line_present,
    input  logic        turn_done,
    output logic        go,
    output logic        veer_rght,
    output logic        veer_lft,
    output logic        turn_ard,
    output logic        buzz_en,
    output logic [2:0]  plan_idx
);

    typedef enum logic [2:0] {
        IDLE,
        FOLLOW,
        GAP_WAIT,
        VEER,
        TURN,
        STOPPED
    } state_t;

    typedef enum logic [1:0] {
        ACT_STOP   = 2'b00,
        ACT_VEER_R = 2'b01,
        ACT_VEER_L = 2'b10,
        ACT_TURN   = 2'b11
    } action_t;

    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);
    localparam logic [15:0] REACQ_LAST = 16'(REACQ_CYC - 1);

    state_t      state, state_nx;
    logic [15:0] plan, plan_nx;
    logic [2:0]  idx_nx;
    logic [15:0] gap_cnt, gap_nx;
    logic [15:0] reacq_cnt, reacq_nx;
    logic        veer_left, veer_left_nx;
    logic        clr_nx;

    logic        accept;
    logic [15:0] plan_adv;
    logic [2:0]  idx_adv;

    // cmd_rdy stays high through the acknowledge cycle (the receiver clears it
    // on the edge after clr_cmd_rdy), so that cycle must not re-accept.
    assign accept = cmd_rdy & ~clr_cmd_rdy;

`ifdef PLAN_LOOP_EN
    assign plan_adv = {plan[1:0], plan[15:2]};
    assign idx_adv  = plan_idx + 3'd1;
`else
    assign plan_adv = {2'b00, plan[15:2]};
    assign idx_adv  = (plan_idx == 3'd7) ? 3'd7 : plan_idx + 3'd1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            plan        <= '0;
            plan_idx    <= '0;
            gap_cnt     <= '0;
            reacq_cnt   <= '0;
            veer_left   <= 1'b0;
            clr_cmd_rdy <= 1'b0;
        end else begin
            state       <= state_nx;
            plan        <= plan_nx;
            plan_idx    <= idx_nx;
            gap_cnt     <= gap_nx;
            reacq_cnt   <= reacq_nx;
            veer_left   <= veer_left_nx;
            clr_cmd_rdy <= clr_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        plan_nx      = plan;
        idx_nx       = plan_idx;
        gap_nx       = gap_cnt;
        reacq_nx     = reacq_cnt;
        veer_left_nx = veer_left;
        clr_nx       = 1'b0;

        case (state)
            IDLE, STOPPED: begin
                if (accept) begin
                    plan_nx  = cmd;
                    idx_nx   = '0;
                    clr_nx   = 1'b1;
                    state_nx = FOLLOW;
                end
            end

            FOLLOW: begin
                // A pending cmd held off during a maneuver lands here on the
                // first FOLLOW cycle.
                if (accept) begin
                    plan_nx = cmd;
                    idx_nx  = '0;
                    clr_nx  = 1'b1;
                end
                if (!line_present) begin
                    gap_nx   = '0;
                    state_nx = GAP_WAIT;
                end
            end

            GAP_WAIT: begin
                if (line_present) begin
                    state_nx = FOLLOW;
                end else if (gap_cnt == GAP_LAST) begin
                    plan_nx = plan_adv;
                    idx_nx  = idx_adv;
                    case (action_t'(plan[1:0]))
                        ACT_STOP:   state_nx = STOPPED;
                        ACT_VEER_R: begin
                            state_nx     = VEER;
                            veer_left_nx = 1'b0;
                            reacq_nx     = '0;
                        end
                        ACT_VEER_L: begin
                            state_nx     = VEER;
                            veer_left_nx = 1'b1;
                            reacq_nx     = '0;
                        end
                        default:    state_nx = TURN;
                    endcase
                end else begin
                    gap_nx = gap_cnt + 16'd1;
                end
            end

            VEER: begin
                if (line_present) begin
                    if (reacq_cnt == REACQ_LAST) begin
                        state_nx = FOLLOW;
                    end else begin
                        reacq_nx = reacq_cnt + 16'd1;
                    end
                end else begin
                    reacq_nx = '0;
                end
            end

            TURN: begin
                if (turn_done) begin
                    state_nx = FOLLOW;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        go        = 1'b0;
        veer_rght = 1'b0;
        veer_lft  = 1'b0;
        turn_ard  = 1'b0;
        buzz_en   = 1'b0;
        case (state)
            FOLLOW, GAP_WAIT: go = 1'b1;
            VEER: begin
                go        = 1'b1;
                veer_rght = ~veer_left;
                veer_lft  = veer_left;
            end
            TURN: begin
                go       = 1'b1;
                turn_ard = 1'b1;
            end
            STOPPED: buzz_en = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_travel_plan_seq.sv
// tb_travel_plan_seq
//   Scoreboard bench for travel_plan_seq. Stimulus tasks predict every change
//   of the output vector {go, veer_rght, veer_lft, turn_ard, buzz_en,
//   clr_cmd_rdy, plan_idx} with the cycle it must appear in; a monitor pops
//   and compares whenever the vector changes.
module tb_travel_plan_seq;

    localparam int GAP   = 24;
    localparam int REACQ = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        line_present;
    logic        turn_done;
    logic        go, veer_rght, veer_lft, turn_ard, buzz_en;
    logic [2:0]  plan_idx;

    travel_plan_seq #(
        .FAST_SIM (1),
        .GAP_CYC  (GAP),
        .REACQ_CYC(REACQ)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .line_present(line_present),
        .turn_done   (turn_done),
        .go          (go),
        .veer_rght   (veer_rght),
        .veer_lft    (veer_lft),
        .turn_ard    (turn_ard),
        .buzz_en     (buzz_en),
        .plan_idx    (plan_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] outs;
    assign outs = {go, veer_rght, veer_lft, turn_ard, buzz_en, clr_cmd_rdy, plan_idx};

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_FOLLOW, M_VEER_R, M_VEER_L, M_TURN, M_STOPPED} mode_t;
    typedef struct { int c; logic [8:0] v; } exp_t;

    mode_t      mode = M_IDLE;
    logic [1:0] plan_q[$];
    int         idx = 0;
    exp_t       exp_q[$];
    logic [8:0] last_v = '0;
    bit         pend = 0;
    logic [15:0] pend_word = '0;
    int         last_rise = 0;

    int checks = 0;
    int failures = 0;

    function automatic logic [8:0] mvec(input bit clr);
        logic g;
        g = (mode == M_FOLLOW) || (mode == M_VEER_R) || (mode == M_VEER_L) || (mode == M_TURN);
        return {g, mode == M_VEER_R, mode == M_VEER_L, mode == M_TURN,
                mode == M_STOPPED, clr, 3'(idx)};
    endfunction

    function automatic void expect_out(input int c, input logic [8:0] v);
        exp_t e;
        if (v != last_v) begin
            e.c = c;
            e.v = v;
            exp_q.push_back(e);
            last_v = v;
        end
    endfunction

    function automatic void load(input logic [15:0] w);
        plan_q.delete();
        for (int i = 0; i < 8; i++) plan_q.push_back(w[2*i +: 2]);
        idx = 0;
    endfunction

    function automatic logic [1:0] advance();
        logic [1:0] a;
        a = plan_q.pop_front();
`ifdef PLAN_LOOP_EN
        plan_q.push_back(a);
        idx = (idx + 1) % 8;
`else
        plan_q.push_back(2'b00);
        if (idx < 7) idx = idx + 1;
`endif
        return a;
    endfunction

    // ---------------- monitor ----------------
    logic [8:0] prev = '0;
    exp_t       got;
    always @(negedge clk) begin
        if (outs !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d got=%b prev=%b required=no change", cyc, outs, prev);
            end else begin
                got = exp_q.pop_front();
                if (got.c != cyc || got.v !== outs) begin
                    failures++;
                    $display("FAIL out_change got=%b@cyc%0d required=%b@cyc%0d", outs, cyc, got.v, got.c);
                end
            end
            prev = outs;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    // Pending cmd is acknowledged in cycle c; receiver drops cmd_rdy a cycle later.
    task automatic take_pending(input int c);
        load(pend_word);
        mode = M_FOLLOW;
        expect_out(c, mvec(1));
        expect_out(c + 1, mvec(0));
        wait_until(c + 1);
        cmd_rdy = 1'b0;
        cmd = 16'($urandom);
        pend = 0;
    endtask

    task automatic send_cmd(input logic [15:0] w);
        pend_word = w;
        pend = 1;
        cmd = w;
        cmd_rdy = 1'b1;
        take_pending(cyc + 1);
    endtask

    task automatic enter_follow(input int f);
        mode = M_FOLLOW;
        expect_out(f, mvec(0));
        wait_until(f);
        if (pend) take_pending(f + 1);
    endtask

    task automatic glitch_gap(input int len);
        line_present = 1'b0;
        tick(len);
        line_present = 1'b1;
        tick(1);
    endtask

    task automatic full_gap(input bit with_pend);
        int k, a, len, poff;
        logic [1:0] act;
        k = cyc;
        a = k + GAP + 1;
        len = with_pend ? GAP + 1 : GAP + 1 + $urandom_range(0, 5);
        poff = $urandom_range(1, GAP);
        act = advance();
        case (act)
            2'b00: mode = M_STOPPED;
            2'b01: mode = M_VEER_R;
            2'b10: mode = M_VEER_L;
            default: mode = M_TURN;
        endcase
        expect_out(a, mvec(0));
        line_present = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (with_pend && i == poff) begin
                pend_word = 16'($urandom);
                cmd = pend_word;
                cmd_rdy = 1'b1;
                pend = 1;
            end
            tick(1);
        end
        line_present = 1'b1;
        last_rise = cyc;
    endtask

    task automatic finish_veer();
        int r, g, d;
        r = last_rise;
        if ($urandom_range(0, 1) == 1) begin
            g = $urandom_range(1, REACQ - 1);
            d = $urandom_range(1, 4);
            wait_until(r + g);
            line_present = 1'b0;
            tick(d);
            line_present = 1'b1;
            r = cyc;
        end
        enter_follow(r + REACQ);
    endtask

    task automatic turn_phase(input bit force_raise);
        int t0;
        if (!pend && (force_raise || $urandom_range(0, 2) == 0)) begin
            pend_word = force_raise ? 16'h0001 : 16'($urandom);
            cmd = pend_word;
            cmd_rdy = 1'b1;
            pend = 1;
        end
        tick($urandom_range(0, 6));
        turn_done = 1'b1;
        t0 = cyc;
        tick(1);
        turn_done = 1'b0;
        enter_follow(t0 + 1);
    endtask

    task automatic do_gap(input bit with_pend);
        full_gap(with_pend);
        case (mode)
            M_VEER_R, M_VEER_L: finish_veer();
            M_TURN:             turn_phase(1'b0);
            M_STOPPED:          if (pend) take_pending(cyc + 1);
            default: ;
        endcase
    endtask

    function automatic logic [15:0] rand_cmd();
        case ($urandom_range(0, 4))
            0: return 16'h0000;
            1: return 16'h0003;
            2: return 16'hAAAA;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        cmd = '0;
        cmd_rdy = 1'b0;
        line_present = 1'b1;
        turn_done = 1'b0;
        tick(3);
        checks++;
        if (outs !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b required=%b", outs, 9'b0);
        end
        rst_n = 1'b1;
        tick(2);

        // turn, then exhausted plan stops
        send_cmd(16'h0003);
        do_gap(1'b0);
        do_gap(1'b0);
        // veer left from STOPPED
        send_cmd(16'h0002);
        do_gap(1'b0);
        // sub-threshold gaps are glitches, then veer right
        send_cmd(16'h0001);
        glitch_gap(GAP - 2);
        glitch_gap(GAP);
        do_gap(1'b0);
        // empty plan stops at first gap, restart from STOPPED
        send_cmd(16'h0000);
        do_gap(1'b0);
        send_cmd(16'h0002);
        // cmd held off during TURN, reload then veer right
        send_cmd(16'h0003);
        full_gap(1'b0);
        turn_phase(1'b1);
        do_gap(1'b0);
        // repeating plan; saturates or wraps depending on build
        send_cmd(16'hAAAA);
        for (int i = 0; i < 9; i++) begin
            if (mode != M_FOLLOW) break;
            do_gap(1'b0);
        end

        // randomized traffic
        for (int it = 0; it < 50; it++) begin
            if (mode == M_IDLE || mode == M_STOPPED) begin
                send_cmd(rand_cmd());
            end else begin
                case ($urandom_range(0, 9))
                    0, 1: glitch_gap($urandom_range(1, GAP));
                    2:    send_cmd(rand_cmd());
                    3: begin
                        turn_done = 1'b1;
                        tick(1);
                        turn_done = 1'b0;
                        tick($urandom_range(1, 3));
                    end
                    default: do_gap($urandom_range(0, 2) == 0);
                endcase
            end
        end

        // reset in the middle of a turn-around drops everything at once
        if (mode != M_FOLLOW) send_cmd(16'h0003);
        else send_cmd(16'h0003);
        full_gap(1'b0);
        tick(2);
        mode = M_IDLE;
        idx = 0;
        plan_q.delete();
        expect_out(cyc, mvec(0));
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        line_present = 1'b0;
        tick(GAP + 4);
        line_present = 1'b1;
        tick(2);
        send_cmd(16'h0002);
        do_gap(1'b0);

        tick(5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_expectations got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/travel_plan_seq.md
# travel_plan_seq

Travel-plan sequencer for the maze runner. It sits between the UART command receiver, which is fed by CommMaster over RX, and the line-following navigation and motor control. It latches the 16-bit travel plan word and tracks line presence to detect gaps. At each confirmed gap it issues the next 2-bit maneuver (stop, veer right, veer left, turn around) to the navigation stage, then advances the plan.

## Interface
Parameters:
- FAST_SIM, 1, selects short debounce windows for simulation.
- GAP_CYC, FAST_SIM ? 512 : 32768, consecutive line-absent cycles that confirm a gap.
- REACQ_CYC, FAST_SIM ? 512 : 32768, consecutive line-present cycles that confirm a veer has reacquired the line.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd  in  16  travel plan from UART receiver; bits [1:0] are consumed first.
- cmd_rdy  in  1  level, a new cmd is valid.
- clr_cmd_rdy  out  1  one-cycle pulse that acknowledges cmd_rdy.
- line_present  in  1  IR line detected (from A2D/sensor stage).
- turn_done  in  1  one-cycle pulse from navigation, 180° maneuver complete.
- go  out  1  enable line-following PID and motors.
- veer_rght  out  1  level, bias right until line reacquired.
- veer_lft  out  1  level, bias left until line reacquired.
- turn_ard  out  1  level, execute turn-around until turn_done.
- buzz_en  out  1  piezo enable while stopped at end of plan.
- plan_idx  out  3  index of the next action to be consumed (0–7).

## Operation
- Action encoding (2 bits): 00 stop, 01 veer right, 10 veer left, 11 turn around.
- States: IDLE, FOLLOW, GAP_WAIT, VEER, TURN, STOPPED.
- IDLE: go=0. On cmd_rdy: load plan←cmd, plan_idx←0, pulse clr_cmd_rdy, go to FOLLOW. Every value is accepted, including 0x0000, which means follow the line and stop at the first gap.
- FOLLOW: go=1. When line_present=0, clear gap_cnt and go to GAP_WAIT.
- GAP_WAIT: go=1, and gap_cnt increments each cycle while line_present=0.
  - line_present=1 → FOLLOW (glitch, no action consumed).
  - gap_cnt==GAP_CYC-1 with line_present=0 → decode plan[1:0]:
    - 00 → STOPPED.
    - 01/10 → VEER, with veer direction latched.
    - 11 → TURN.
  - On every exit to VEER, TURN or STOPPED, the plan shifts right by 2 (zero fill) and plan_idx increments, saturating at 7.
- VEER: go=1, and exactly one of veer_rght/veer_lft is high.
  - reacq_cnt increments while line_present=1 and clears on line_present=0.
  - reacq_cnt==REACQ_CYC-1 → FOLLOW.
- TURN: go=1, turn_ard=1. On turn_done → FOLLOW; line_present is ignored in this state.
- STOPPED: go=0, buzz_en=1. On cmd_rdy: reload as in IDLE and go to FOLLOW.
- cmd_rdy in FOLLOW: reload the plan immediately and pulse clr_cmd_rdy.
- cmd_rdy in GAP_WAIT/VEER/TURN: hold off. clr_cmd_rdy is not pulsed until the state returns to FOLLOW, and the reload occurs on the first FOLLOW cycle.
- A simultaneous cmd_rdy and gap-confirm in GAP_WAIT resolves to the gap action first; the cmd stays pending.
- Once the plan is exhausted it reads 0, so the next gap stops the robot.

## Timing
- All outputs are Moore, decoded from registered state. They change on the edge that enters the state.
- Reset value of every output is 0: go, veer_rght, veer_lft, turn_ard, buzz_en, clr_cmd_rdy, and plan_idx=0. State resets to IDLE, and plan, gap_cnt and reacq_cnt reset to 0.
- clr_cmd_rdy is high for exactly one cycle, on the edge after cmd_rdy is sampled in an accepting state.
- Gap latency: the action outputs assert GAP_CYC+1 clocks after line_present first falls in FOLLOW. That is 1 cycle into GAP_WAIT plus GAP_CYC counting cycles.
- Veer release: FOLLOW is re-entered REACQ_CYC clocks after line_present last rose in VEER.
- Counters are 16 bits and cannot wrap, because the compare ends the count before overflow.
- Reset mid-maneuver returns to IDLE in the same instant. The plan is lost.

## Configuration
- PLAN_LOOP_EN defined: the plan rotates right by 2 instead of shifting, so consumed actions recirculate. For example, 0xAAAA veers left forever, and plan_idx wraps 7→0.
- PLAN_LOOP_EN undefined: zero-fill shift as above, and plan_idx saturates at 7.

## Test plan
- Reset, then cmd=0x0003 and cmd_rdy. Require a one-cycle clr_cmd_rdy pulse and go=1. Drop line_present for GAP_CYC+5 cycles: turn_ard=1 exactly GAP_CYC+1 clocks after the fall. Pulse turn_done → FOLLOW. The next gap gives go=0 and buzz_en=1.
- cmd=0x0002, then a line gap followed by line_present=1 for REACQ_CYC cycles. Require veer_lft high through the gap and reacquire, then FOLLOW with veer_lft=0 and plan_idx=1.
- cmd=0x0001, with the line dropped for GAP_CYC-2 cycles then restored. No veer_rght assertion and plan_idx stays 0. A full gap then asserts veer_rght.
- cmd=0x0000 followed by a full gap. Require go=0 and buzz_en=1. A new cmd=0x0002 in STOPPED restarts with go=1.
- cmd_rdy with cmd=0x0001 asserted during TURN (plan 0x0003). clr_cmd_rdy stays low until turn_done. The reloaded plan then veers right at the next gap.
- With PLAN_LOOP_EN, cmd=0xAAAA over 9 gaps: veer_lft is asserted at all 9 gaps, go never drops, and plan_idx wraps back to 1.
